// File: rtl/edge_event_pkg.sv
// Shared definitions for the edge event unit: the per-channel edge-select
// mode field and the helper that decides whether a level change is an event.
package edge_event_pkg;

    // Per-channel edge select: bit 0 enables rising edges, bit 1 falling edges.
    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF  = 2'b00;
    localparam mode_t MODE_RISE = 2'b01;
    localparam mode_t MODE_FALL = 2'b10;
    localparam mode_t MODE_BOTH = 2'b11;

    // True when a level change to new_level is selected by mode.
    // A change to 1 is a rise, a change to 0 is a fall.
    function automatic logic edge_qualifies(input mode_t mode, input logic new_level);
        logic rise_en;
        logic fall_en;
        rise_en = |(mode & MODE_RISE);
        fall_en = |(mode & MODE_FALL);
        return new_level ? rise_en : fall_en;
    endfunction

endpackage

// File: rtl/edge_event_chan.sv
// One input channel: synchroniser, debounce counter, accepted level,
// edge qualification against the run-time mode, and the sticky
// pending/overflow flags with write-1-to-clear.
module edge_event_chan
    import edge_event_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 16
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  in_i,
    input  mode_t mode_i,
    input  logic  clear_i,
    output logic  level_o,
    output logic  pulse_o,
    output logic  pending_o,
    output logic  overflow_o,
    output logic  pending_next_o
);

    // The counter must be able to hold DEBOUNCE-1 without wrapping.
    localparam int               CNT_W    = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_s;

    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   level_q;
    logic                   level_d;
    logic                   level_change;

    logic                   event_hit;
    logic                   pulse_q;
    logic                   pulse_d;
    logic                   pending_q;
    logic                   pending_d;
    logic                   overflow_q;
    logic                   overflow_d;

    // The raw input enters at bit 0 and leaves the chain at the top bit.
    assign sync_d = {sync_q[SYNC_STAGES-2:0], in_i};
    assign sync_s = sync_q[SYNC_STAGES-1];

    // Debounce: count consecutive cycles where the synchronised input
    // disagrees with the accepted level; accept it after DEBOUNCE cycles,
    // and drop the count as soon as the input falls back (glitch rejected).
    always_comb begin
        cnt_d        = cnt_q;
        level_d      = level_q;
        level_change = 1'b0;
        if (sync_s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d        = '0;
            level_d      = sync_s;
            level_change = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Mode is only looked at on the cycle the level actually changes, so a
    // mode write on its own can never create or cancel an event.
    assign event_hit = level_change & edge_qualifies(mode_i, level_d);
    assign pulse_d   = event_hit;

    // Sticky flags: an event always sets pending (it beats a same-cycle
    // clear); an event is only counted as lost when pending was already set
    // and no clear is arriving in the same cycle.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (event_hit) begin
            pending_d = 1'b1;
        end else if (clear_i) begin
            pending_d = 1'b0;
        end
        if (clear_i) begin
            overflow_d = 1'b0;
        end else if (event_hit && pending_q) begin
            overflow_d = 1'b1;
        end
    end

    // All channel state, cleared asynchronously so reset takes effect at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            pulse_q    <= 1'b0;
            pending_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            pulse_q    <= pulse_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign level_o        = level_q;
    assign pulse_o        = pulse_q;
    assign pending_o      = pending_q;
    assign overflow_o     = overflow_q;
    assign pending_next_o = pending_d;

endmodule

// File: rtl/edge_event_unit.sv
// Multi-channel edge event unit: one independent edge_event_chan per input,
// plus a registered interrupt that is the OR of all pending flags.
module edge_event_unit
    import edge_event_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS-1:0]   in,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   clear,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   pulse,
    output logic [CHANNELS-1:0]   pending,
    output logic [CHANNELS-1:0]   overflow,
    output logic                  irq
);

    logic [CHANNELS-1:0] pending_next;
    logic                irq_q;
    logic                irq_d;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        edge_event_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE    (DEBOUNCE)
        ) u_chan (
            .clk_i          (clk),
            .rst_ni         (rst_n),
            .in_i           (in[c]),
            .mode_i         (mode[2*c +: 2]),
            .clear_i        (clear[c]),
            .level_o        (level[c]),
            .pulse_o        (pulse[c]),
            .pending_o      (pending[c]),
            .overflow_o     (overflow[c]),
            .pending_next_o (pending_next[c])
        );
    end

    // Built from the next-state pending bits so irq rises and falls in the
    // same cycle as the pending flags themselves.
    assign irq_d = |pending_next;

    // Interrupt register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_edge_event_unit.sv
// Bench for edge_event_unit (4 channels, 2 sync stages, debounce 4).
// Expected pulses are queued with their expected cycle when stimulus is
// driven; a monitor queues observed pulses; each scenario compares them.
module tb_edge_event_unit;
    import edge_event_pkg::*;

    localparam int CH   = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    // Input driven on a falling edge is captured on the next rising edge;
    // the pulse is then seen on the falling edge SYNC+DEB cycles later.
    localparam int LAT  = SYNC + DEB;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [CH-1:0]   in_s = '0;
    logic [2*CH-1:0] mode_s = '0;
    logic [CH-1:0]   clear_s = '0;
    logic [CH-1:0]   level_s;
    logic [CH-1:0]   pulse_s;
    logic [CH-1:0]   pending_s;
    logic [CH-1:0]   overflow_s;
    logic            irq_s;

    typedef struct {
        int ch;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_q[$];
    ev_t mon_e;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    edge_event_unit #(
        .CHANNELS    (CH),
        .SYNC_STAGES (SYNC),
        .DEBOUNCE    (DEB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in_s),
        .mode     (mode_s),
        .clear    (clear_s),
        .level    (level_s),
        .pulse    (pulse_s),
        .pending  (pending_s),
        .overflow (overflow_s),
        .irq      (irq_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int c = 0; c < CH; c++) begin
            if (pulse_s[c] === 1'b1) begin
                mon_e.ch  = c;
                mon_e.cyc = cyc;
                obs_q.push_back(mon_e);
            end
        end
    end

    task automatic expect_pulse(input int ch);
        ev_t e;
        e.ch  = ch;
        e.cyc = cyc + LAT;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        in_s    = '0;
        mode_s  = '0;
        clear_s = '0;
        repeat (3) @(negedge clk);
        checks++; if (level_s !== 4'b0000) begin errors++; $display("FAIL reset_level: got %b want 0000", level_s); end
        checks++; if (pulse_s !== 4'b0000) begin errors++; $display("FAIL reset_pulse: got %b want 0000", pulse_s); end
        checks++; if (pending_s !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b want 0000", pending_s); end
        checks++; if (overflow_s !== 4'b0000) begin errors++; $display("FAIL reset_overflow: got %b want 0000", overflow_s); end
        checks++; if (irq_s !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq_s); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_clean_rise;
        ev_t e, o;
        @(negedge clk);
        mode_s = {MODE_BOTH, MODE_BOTH, MODE_BOTH, MODE_RISE};
        in_s[0] = 1'b1;
        expect_pulse(0);
        repeat (LAT - 1) @(negedge clk);
        checks++; if (pulse_s[0] !== 1'b0) begin errors++; $display("FAIL rise_early_pulse: got %b want 0", pulse_s[0]); end
        checks++; if (pending_s[0] !== 1'b0) begin errors++; $display("FAIL rise_early_pending: got %b want 0", pending_s[0]); end
        @(negedge clk);
        checks++; if (pulse_s !== 4'b0001) begin errors++; $display("FAIL rise_pulse: got %b want 0001", pulse_s); end
        checks++; if (level_s !== 4'b0001) begin errors++; $display("FAIL rise_level: got %b want 0001", level_s); end
        checks++; if (pending_s !== 4'b0001) begin errors++; $display("FAIL rise_pending: got %b want 0001", pending_s); end
        checks++; if (irq_s !== 1'b1) begin errors++; $display("FAIL rise_irq: got %b want 1", irq_s); end
        @(negedge clk);
        checks++; if (pulse_s !== 4'b0000) begin errors++; $display("FAIL rise_pulse_width: got %b want 0000", pulse_s); end
        checks++; if (pending_s !== 4'b0001) begin errors++; $display("FAIL rise_pending_sticky: got %b want 0001", pending_s); end
        repeat (4) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL rise_sb: no pulse, want ch%0d at cycle %0d", e.ch, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.ch !== e.ch || o.cyc !== e.cyc) begin
                    errors++; $display("FAIL rise_sb: got ch%0d cycle %0d want ch%0d cycle %0d", o.ch, o.cyc, e.ch, e.cyc);
                end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rise_sb_extra: got %0d extra pulses want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_glitch;
        ev_t e, o;
        @(negedge clk);
        in_s[1] = 1'b1;
        repeat (3) @(negedge clk);
        in_s[1] = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (level_s[1] !== 1'b0) begin errors++; $display("FAIL glitch3_level: got %b want 0", level_s[1]); end
        in_s[1] = 1'b1;
        @(negedge clk);
        in_s[1] = 1'b0;
        repeat (8) @(negedge clk);
        checks++; if (level_s[1] !== 1'b0) begin errors++; $display("FAIL glitch1_level: got %b want 0", level_s[1]); end
        // A held step must still take the full latency, proving the count restarted.
        in_s[1] = 1'b1;
        expect_pulse(1);
        repeat (LAT + 2) @(negedge clk);
        checks++; if (level_s[1] !== 1'b1) begin errors++; $display("FAIL glitch_step_level: got %b want 1", level_s[1]); end
        in_s[1] = 1'b0;
        expect_pulse(1);
        repeat (LAT + 2) @(negedge clk);
        checks++; if (level_s[1] !== 1'b0) begin errors++; $display("FAIL glitch_fall_level: got %b want 0", level_s[1]); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL glitch_sb: no pulse, want ch%0d at cycle %0d", e.ch, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.ch !== e.ch || o.cyc !== e.cyc) begin
                    errors++; $display("FAIL glitch_sb: got ch%0d cycle %0d want ch%0d cycle %0d", o.ch, o.cyc, e.ch, e.cyc);
                end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL glitch_sb_extra: got %0d extra pulses want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_modes;
        ev_t   e, o;
        mode_t mds [4];
        logic  want_pend;
        logic  want_ovf;
        mds[0] = MODE_RISE;
        mds[1] = MODE_FALL;
        mds[2] = MODE_BOTH;
        mds[3] = MODE_OFF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clear_s[2] = 1'b1;
            @(negedge clk);
            clear_s[2] = 1'b0;
            mode_s[5:4] = mds[i];
            in_s[2] = 1'b1;
            if (mds[i][0]) expect_pulse(2);
            repeat (LAT + 3) @(negedge clk);
            checks++; if (level_s[2] !== 1'b1) begin errors++; $display("FAIL mode%0d_level_hi: got %b want 1", i, level_s[2]); end
            in_s[2] = 1'b0;
            if (mds[i][1]) expect_pulse(2);
            repeat (LAT + 3) @(negedge clk);
            checks++; if (level_s[2] !== 1'b0) begin errors++; $display("FAIL mode%0d_level_lo: got %b want 0", i, level_s[2]); end
            want_pend = (mds[i] != MODE_OFF);
            want_ovf  = (mds[i] == MODE_BOTH);
            checks++; if (pending_s[2] !== want_pend) begin errors++; $display("FAIL mode%0d_pending: got %b want %b", i, pending_s[2], want_pend); end
            checks++; if (overflow_s[2] !== want_ovf) begin errors++; $display("FAIL mode%0d_overflow: got %b want %b", i, overflow_s[2], want_ovf); end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (obs_q.size() == 0) begin
                    errors++; $display("FAIL mode%0d_sb: no pulse, want ch%0d at cycle %0d", i, e.ch, e.cyc);
                end else begin
                    o = obs_q.pop_front();
                    if (o.ch !== e.ch || o.cyc !== e.cyc) begin
                        errors++; $display("FAIL mode%0d_sb: got ch%0d cycle %0d want ch%0d cycle %0d", i, o.ch, o.cyc, e.ch, e.cyc);
                    end
                end
            end
            checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mode%0d_sb_extra: got %0d extra pulses want 0", i, obs_q.size()); end
            obs_q.delete();
        end
        // Switching mode with a steady input must not create an event.
        @(negedge clk);
        mode_s[5:4] = MODE_BOTH;
        repeat (LAT + 4) @(negedge clk);
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mode_switch_pulse: got %0d pulses want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_overflow_clear;
        ev_t e, o;
        @(negedge clk);
        clear_s = '1;
        @(negedge clk);
        clear_s = '0;
        checks++; if (pending_s !== 4'b0000) begin errors++; $display("FAIL ovf_clear_all: got %b want 0000", pending_s); end
        checks++; if (irq_s !== 1'b0) begin errors++; $display("FAIL ovf_irq_idle: got %b want 0", irq_s); end
        mode_s[7:6] = MODE_BOTH;
        in_s[3] = 1'b1;
        expect_pulse(3);
        repeat (LAT + 2) @(negedge clk);
        checks++; if ({pending_s[3], overflow_s[3]} !== 2'b10) begin errors++; $display("FAIL ovf_first: got p%b o%b want p1 o0", pending_s[3], overflow_s[3]); end
        checks++; if (irq_s !== 1'b1) begin errors++; $display("FAIL ovf_irq: got %b want 1", irq_s); end
        in_s[3] = 1'b0;
        expect_pulse(3);
        repeat (LAT + 2) @(negedge clk);
        checks++; if ({pending_s[3], overflow_s[3]} !== 2'b11) begin errors++; $display("FAIL ovf_second: got p%b o%b want p1 o1", pending_s[3], overflow_s[3]); end
        clear_s[3] = 1'b1;
        @(negedge clk);
        clear_s[3] = 1'b0;
        checks++; if ({pending_s[3], overflow_s[3]} !== 2'b00) begin errors++; $display("FAIL ovf_clear: got p%b o%b want p0 o0", pending_s[3], overflow_s[3]); end
        checks++; if (irq_s !== 1'b0) begin errors++; $display("FAIL ovf_clear_irq: got %b want 0", irq_s); end
        // Rebuild overflow, then clear in the very cycle of a new event.
        in_s[3] = 1'b1;
        expect_pulse(3);
        repeat (LAT + 2) @(negedge clk);
        in_s[3] = 1'b0;
        expect_pulse(3);
        repeat (LAT + 2) @(negedge clk);
        checks++; if (overflow_s[3] !== 1'b1) begin errors++; $display("FAIL ovf_rebuild: got %b want 1", overflow_s[3]); end
        in_s[3] = 1'b1;
        expect_pulse(3);
        repeat (LAT - 1) @(negedge clk);
        clear_s[3] = 1'b1;
        @(negedge clk);
        clear_s[3] = 1'b0;
        checks++; if (pulse_s[3] !== 1'b1) begin errors++; $display("FAIL ovf_coinc_pulse: got %b want 1", pulse_s[3]); end
        checks++; if ({pending_s[3], overflow_s[3]} !== 2'b10) begin errors++; $display("FAIL ovf_coinc: got p%b o%b want p1 o0", pending_s[3], overflow_s[3]); end
        @(negedge clk);
        checks++; if ({pending_s[3], overflow_s[3]} !== 2'b10) begin errors++; $display("FAIL ovf_coinc_hold: got p%b o%b want p1 o0", pending_s[3], overflow_s[3]); end
        repeat (4) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL ovf_sb: no pulse, want ch%0d at cycle %0d", e.ch, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.ch !== e.ch || o.cyc !== e.cyc) begin
                    errors++; $display("FAIL ovf_sb: got ch%0d cycle %0d want ch%0d cycle %0d", o.ch, o.cyc, e.ch, e.cyc);
                end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL ovf_sb_extra: got %0d extra pulses want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_reset_mid;
        ev_t e, o;
        @(negedge clk);
        in_s[0] = 1'b0;
        repeat (LAT + 3) @(negedge clk);
        checks++; if (irq_s !== 1'b1) begin errors++; $display("FAIL rstmid_pre_irq: got %b want 1", irq_s); end
        checks++; if (level_s !== 4'b1000) begin errors++; $display("FAIL rstmid_pre_level: got %b want 1000", level_s); end
        in_s[0] = 1'b1;
        // Two edges after the step reaches the sync output the count is 2.
        repeat (SYNC + 2) @(negedge clk);
        #1;
        rst_n   = 1'b0;
        in_s[3] = 1'b0;
        #1;
        checks++; if (level_s !== 4'b0000) begin errors++; $display("FAIL rstmid_level: got %b want 0000", level_s); end
        checks++; if (pulse_s !== 4'b0000) begin errors++; $display("FAIL rstmid_pulse: got %b want 0000", pulse_s); end
        checks++; if (pending_s !== 4'b0000) begin errors++; $display("FAIL rstmid_pending: got %b want 0000", pending_s); end
        checks++; if (overflow_s !== 4'b0000) begin errors++; $display("FAIL rstmid_overflow: got %b want 0000", overflow_s); end
        checks++; if (irq_s !== 1'b0) begin errors++; $display("FAIL rstmid_irq: got %b want 0", irq_s); end
        repeat (3) @(negedge clk);
        checks++; if (level_s !== 4'b0000) begin errors++; $display("FAIL rstmid_hold_level: got %b want 0000", level_s); end
        rst_n = 1'b1;
        expect_pulse(0);
        repeat (LAT - 1) @(negedge clk);
        checks++; if (pulse_s[0] !== 1'b0) begin errors++; $display("FAIL rstmid_early_pulse: got %b want 0", pulse_s[0]); end
        @(negedge clk);
        checks++; if (pulse_s !== 4'b0001) begin errors++; $display("FAIL rstmid_pulse_after: got %b want 0001", pulse_s); end
        checks++; if (pending_s !== 4'b0001) begin errors++; $display("FAIL rstmid_pending_after: got %b want 0001", pending_s); end
        checks++; if (irq_s !== 1'b1) begin errors++; $display("FAIL rstmid_irq_after: got %b want 1", irq_s); end
        repeat (4) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL rstmid_sb: no pulse, want ch%0d at cycle %0d", e.ch, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.ch !== e.ch || o.cyc !== e.cyc) begin
                    errors++; $display("FAIL rstmid_sb: got ch%0d cycle %0d want ch%0d cycle %0d", o.ch, o.cyc, e.ch, e.cyc);
                end
            end
        end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL rstmid_sb_extra: got %0d extra pulses want 0", obs_q.size()); end
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_glitch();
        test_modes();
        test_overflow_clear();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
